// File: rtl/alu_flag_pipe.sv
// Registered ARM data-processing ALU with an internal NZCV flag register
// and a one-entry output buffer behind a valid/ready handshake.
module alu_flag_pipe #(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       FN,
  input  logic             S,
  input  logic [WIDTH-1:0] LEFT_OP,
  input  logic [WIDTH-1:0] RIGHT_OP,
  input  logic             SHIFT_C,
  input  logic             FLAG_LOAD,
  input  logic [3:0]       FLAG_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUTPUT,
  output logic             RD_WE,
  output logic [3:0]       FLAGS
);

  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             rd_we_p1;
  logic [3:0]       nzcv;

  logic             accept_p0;
  logic             arith_p0;
  logic             cin_p0;
  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH-1:0] res_p0;
  logic [3:0]       nzcv_p0;
  logic             set_p0;
  logic             rd_we_p0;

  function automatic logic [WIDTH-1:0] logic_op(input logic [3:0] fn,
                                                input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] y;
    case (fn)
      4'b0000, 4'b1000: y = l & r;
      4'b0001, 4'b1001: y = l ^ r;
      4'b1100:          y = l | r;
      4'b1101:          y = r;
      4'b1110:          y = l & ~r;
      default:          y = ~r;
    endcase
    return y;
  endfunction

  function automatic logic overflow(input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign IN_READY  = !vld_p1 || OUT_READY;
  assign accept_p0 = IN_VALID && IN_READY;

  // Stage p0: operand routing, adder, logic unit and flag generation.
  // Subtracts are folded into the adder as A + ~B + cin, so C is NOT borrow.
  always_comb begin
    op_a_p0  = LEFT_OP;
    op_b_p0  = RIGHT_OP;
    cin_p0   = 1'b0;
    arith_p0 = 1'b1;
    case (FN)
      4'b0010, 4'b1010: begin op_b_p0 = ~RIGHT_OP; cin_p0 = 1'b1; end
      4'b0011: begin op_a_p0 = RIGHT_OP; op_b_p0 = ~LEFT_OP; cin_p0 = 1'b1; end
      4'b0101: cin_p0 = nzcv[1];
      4'b0110: begin op_b_p0 = ~RIGHT_OP; cin_p0 = nzcv[1]; end
      4'b0111: begin op_a_p0 = RIGHT_OP; op_b_p0 = ~LEFT_OP; cin_p0 = nzcv[1]; end
      4'b0100, 4'b1011: cin_p0 = 1'b0;
      default: arith_p0 = 1'b0;
    endcase
    sum_p0   = {1'b0, op_a_p0} + {1'b0, op_b_p0} + {{WIDTH{1'b0}}, cin_p0};
    res_p0   = arith_p0 ? sum_p0[WIDTH-1:0] : logic_op(FN, LEFT_OP, RIGHT_OP);
    nzcv_p0[3] = res_p0[WIDTH-1];
    nzcv_p0[2] = (res_p0 == '0);
    nzcv_p0[1] = arith_p0 ? sum_p0[WIDTH] : SHIFT_C;
    nzcv_p0[0] = arith_p0 ? overflow(op_a_p0[WIDTH-1], op_b_p0[WIDTH-1], res_p0[WIDTH-1])
                          : nzcv[0];
    set_p0   = S || (FN[3:2] == 2'b10);
    rd_we_p0 = (FN[3:2] != 2'b10);
  end

  // Stage p1: output buffer and architectural flag register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      rd_we_p1 <= 1'b0;
      nzcv     <= FLAG_RESET;
    end else begin
      if (accept_p0) begin
        vld_p1   <= 1'b1;
        res_p1   <= res_p0;
        rd_we_p1 <= rd_we_p0;
      end else if (OUT_READY) begin
        vld_p1   <= 1'b0;
      end
      // An accepted flag-setting op takes priority over a direct flag write.
      if (accept_p0 && set_p0) begin
        nzcv <= nzcv_p0;
      end else if (FLAG_LOAD) begin
        nzcv <= FLAG_IN;
      end
    end
  end

  assign OUT_VALID  = vld_p1;
  assign ALU_OUTPUT = res_p1;
  assign RD_WE      = rd_we_p1;
  assign FLAGS      = nzcv;

endmodule

// File: tb/tb_alu_flag_pipe.sv
// Directed bench for alu_flag_pipe: a 32-bit instance (FLAG_RESET=0010)
// and an 8-bit instance driven one after the other from a shared clock.
module tb_alu_flag_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_s, a_shift_c, a_flag_load;
  logic        a_out_valid, a_out_ready, a_rd_we;
  logic [3:0]  a_fn, a_flag_in, a_flags;
  logic [31:0] a_l, a_r, a_out;

  logic        b_in_valid, b_in_ready, b_s, b_shift_c, b_flag_load;
  logic        b_out_valid, b_out_ready, b_rd_we;
  logic [3:0]  b_fn, b_flag_in, b_flags;
  logic [7:0]  b_l, b_r, b_out;

  int checks = 0;
  int failures = 0;

  alu_flag_pipe #(.WIDTH(32), .FLAG_RESET(4'b0010)) u_a (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .FN(a_fn), .S(a_s), .LEFT_OP(a_l), .RIGHT_OP(a_r), .SHIFT_C(a_shift_c),
    .FLAG_LOAD(a_flag_load), .FLAG_IN(a_flag_in), .OUT_VALID(a_out_valid),
    .OUT_READY(a_out_ready), .ALU_OUTPUT(a_out), .RD_WE(a_rd_we), .FLAGS(a_flags)
  );

  alu_flag_pipe #(.WIDTH(8), .FLAG_RESET(4'b0000)) u_b (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .FN(b_fn), .S(b_s), .LEFT_OP(b_l), .RIGHT_OP(b_r), .SHIFT_C(b_shift_c),
    .FLAG_LOAD(b_flag_load), .FLAG_IN(b_flag_in), .OUT_VALID(b_out_valid),
    .OUT_READY(b_out_ready), .ALU_OUTPUT(b_out), .RD_WE(b_rd_we), .FLAGS(b_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic [3:0] fn, input logic s,
                      input logic [31:0] l, input logic [31:0] r);
    a_in_valid = 1'b1; a_fn = fn; a_s = s; a_l = l; a_r = r;
  endtask

  task automatic b_op(input logic [3:0] fn, input logic s, input logic sc,
                      input logic [7:0] l, input logic [7:0] r);
    b_in_valid = 1'b1; b_fn = fn; b_s = s; b_shift_c = sc; b_l = l; b_r = r;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_s = 0; a_shift_c = 0; a_flag_load = 0; a_flag_in = 0;
    a_out_ready = 1; a_fn = 0; a_l = 0; a_r = 0;
    b_in_valid = 0; b_s = 0; b_shift_c = 0; b_flag_load = 0; b_flag_in = 0;
    b_out_ready = 1; b_fn = 0; b_l = 0; b_r = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", a_flags, 4'b0010);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out", a_out, 0);
    check("rst_rd_we", a_rd_we, 0);
    check("rst_flags8", b_flags, 4'b0000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", a_in_ready, 1);
    tick();
    check("idle_out_valid", a_out_valid, 0);

    a_op(4'b0100, 1, 32'h7FFF_FFFF, 32'h1);
    tick();
    check("add_ovf_out", a_out, 32'h8000_0000);
    check("add_ovf_rd_we", a_rd_we, 1);
    check("add_ovf_flags", a_flags, 4'b1001);
    check("add_ovf_valid", a_out_valid, 1);

    a_op(4'b1010, 0, 32'd5, 32'd5);
    tick();
    check("cmp_out", a_out, 0);
    check("cmp_rd_we", a_rd_we, 0);
    check("cmp_flags", a_flags, 4'b0110);

    a_op(4'b0110, 1, 32'd5, 32'd5);
    tick();
    check("sbc_out", a_out, 0);
    check("sbc_flags", a_flags, 4'b0110);

    a_op(4'b0100, 1, 32'hFFFF_FFFF, 32'h1);
    tick();
    check("add_carry_out", a_out, 0);
    check("add_carry_flags", a_flags, 4'b0110);
    a_op(4'b0101, 1, 32'h0, 32'h0);
    tick();
    check("adc_b2b_out", a_out, 32'h1);
    check("adc_b2b_valid", a_out_valid, 1);
    check("adc_b2b_flags", a_flags, 4'b0000);

    a_op(4'b0100, 1, 32'd2, 32'd3);
    tick();
    check("add5_out", a_out, 32'd5);
    a_out_ready = 0;
    a_op(4'b0010, 1, 32'd1, 32'd2);
    #1;
    check("stall_in_ready", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out", a_out, 32'd5);
      check("stall_valid", a_out_valid, 1);
      check("stall_flags", a_flags, 4'b0000);
      check("stall_in_ready_hold", a_in_ready, 0);
    end
    a_out_ready = 1;
    #1;
    check("release_in_ready", a_in_ready, 1);
    tick();
    check("sub_neg_out", a_out, 32'hFFFF_FFFF);
    check("sub_neg_flags", a_flags, 4'b1000);
    a_op(4'b1101, 0, 32'hDEAD_BEEF, 32'h1234);
    tick();
    check("mov_out", a_out, 32'h1234);
    check("mov_rd_we", a_rd_we, 1);
    check("mov_flags", a_flags, 4'b1000);
    a_in_valid = 0;
    tick();
    check("drain_valid", a_out_valid, 0);
    check("drain_in_ready", a_in_ready, 1);

    a_flag_load = 1; a_flag_in = 4'b1010;
    tick();
    a_flag_load = 0;
    check("msr_flags", a_flags, 4'b1010);

    a_out_ready = 0;
    a_op(4'b0100, 1, 32'd1, 32'd1);
    tick();
    a_in_valid = 0;
    check("pre_rst_valid", a_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_out", a_out, 0);
    check("midrst_flags", a_flags, 4'b0010);
    rst_n = 1'b1;
    a_out_ready = 1;
    tick();

    b_op(4'b0010, 1, 0, 8'h00, 8'h01);
    tick();
    check("w8_sub_out", b_out, 8'hFF);
    check("w8_sub_flags", b_flags, 4'b1000);
    b_op(4'b0100, 1, 0, 8'h7F, 8'h01);
    tick();
    check("w8_add_out", b_out, 8'h80);
    check("w8_add_flags", b_flags, 4'b1001);
    b_op(4'b1100, 1, 1, 8'h10, 8'h01);
    tick();
    check("w8_orr_out", b_out, 8'h11);
    check("w8_orr_flags", b_flags, 4'b0011);
    b_op(4'b1010, 0, 0, 8'h03, 8'h03);
    b_flag_load = 1; b_flag_in = 4'b1111;
    tick();
    check("w8_cmp_load_out", b_out, 8'h00);
    check("w8_cmp_load_rd_we", b_rd_we, 0);
    check("w8_cmp_load_flags", b_flags, 4'b0110);
    b_in_valid = 0;
    tick();
    b_flag_load = 0;
    check("w8_msr_flags", b_flags, 4'b1111);
    check("w8_msr_drain", b_out_valid, 0);
    b_op(4'b1111, 1, 0, 8'h55, 8'h0F);
    tick();
    check("w8_mvn_out", b_out, 8'hF0);
    check("w8_mvn_flags", b_flags, 4'b1001);
    b_op(4'b1001, 0, 1, 8'hAA, 8'hAA);
    tick();
    check("w8_teq_out", b_out, 8'h00);
    check("w8_teq_rd_we", b_rd_we, 0);
    check("w8_teq_flags", b_flags, 4'b0111);
    b_op(4'b0011, 1, 0, 8'h05, 8'h03);
    tick();
    check("w8_rsb_out", b_out, 8'hFE);
    check("w8_rsb_flags", b_flags, 4'b1000);
    b_op(4'b1110, 0, 1, 8'hFF, 8'h0F);
    tick();
    check("w8_bic_out", b_out, 8'hF0);
    check("w8_bic_rd_we", b_rd_we, 1);
    check("w8_bic_flags", b_flags, 4'b1000);
    b_in_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_flag_pipe.md
Name: alu_flag_pipe

Overview:
- Parametrised, registered successor to the combinational ARM data-processing ALU.
- Executes all 16 data-processing opcodes at WIDTH bits under a valid/ready handshake, with one-cycle latency and a one-entry output buffer.
- Holds the architectural NZCV flag register internally; it sources the carry-in from it and updates it per ARM rules.
- Sits between operand fetch/shifter and register-file writeback.

Parameters:
- WIDTH, 32, datapath width in bits (legal 8..64).
- FLAG_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operation presented.
- IN_READY  out  1  block can accept an operation this cycle.
- FN  in  4  opcode (0000 AND … 1111 MVN, ARM encoding).
- S  in  1  set-flags request.
- LEFT_OP  in  WIDTH  Rn.
- RIGHT_OP  in  WIDTH  shifter operand.
- SHIFT_C  in  1  shifter carry-out, used as C by logical ops.
- FLAG_LOAD  in  1  direct flag write (MSR).
- FLAG_IN  in  4  NZCV value for FLAG_LOAD.
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  consumer takes result.
- ALU_OUTPUT  out  WIDTH  result.
- RD_WE  out  1  result is to be written (0 for TST/TEQ/CMP/CMN).
- FLAGS  out  4  current NZCV register {N,Z,C,V}.

Behaviour:
- Reset (async, RESET_N=0):
  - OUT_VALID=0, ALU_OUTPUT=0, RD_WE=0, FLAGS=FLAG_RESET.
  - IN_READY is 1 as soon as RESET_N=1.
  - Reset mid-operation discards the buffered result without delivering it.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - An accept occurs on an edge where IN_VALID && IN_READY.
  - Accept → next cycle OUT_VALID=1, ALU_OUTPUT/RD_WE hold that operation's values.
  - Output fields stay stable while OUT_VALID && !OUT_READY.
  - OUT_VALID clears on an edge with OUT_READY && !accept.
  - Simultaneous drain and accept → buffer replaced, OUT_VALID stays 1. Full throughput is 1 op/cycle.
- Arithmetic: unsigned (WIDTH+1)-bit sum of A + B + cin.
  - ADD: A=L, B=R, cin=0.
  - ADC: A=L, B=R, cin=C.
  - SUB/CMP: A=L, B=~R, cin=1.
  - SBC: A=L, B=~R, cin=C.
  - RSB: A=R, B=~L, cin=1.
  - RSC: A=R, B=~L, cin=C.
  - CMN: A=L, B=R, cin=0.
  - C = bit WIDTH of the sum (subtract C = NOT borrow).
  - V = (A[W-1]==B[W-1]) && (res[W-1]!=A[W-1]).
- Logical (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - TST uses bitwise AND; MOV/MVN ignore LEFT_OP.
  - C = SHIFT_C, V unchanged.
- N = res[W-1]; Z = (res==0).
- Flag register:
  - Updated on the accept edge when S=1 or FN=10xx; compare ops update flags regardless of S.
  - Flag-updating ops also present their result on ALU_OUTPUT with RD_WE=0.
  - cin reads the register value before the edge. Back-to-back ops therefore see the previous accepted op's flags with no bubble.
- FLAG_LOAD writes FLAG_IN on the edge.
  - If FLAG_LOAD coincides with a flag-updating accept, the accepted op's flags win.
  - FLAG_LOAD is independent of the handshake; an op stalled on IN_READY does not touch the flags.
- RD_WE=1 for FN ∉ {1000,1001,1010,1011}.
- No hidden state beyond the output buffer and the flag register. Delays are not modelled (synthesisable).

Test Plan:
- Reset with FLAG_RESET=4'b0010, release, IN_VALID=0 → FLAGS=0010, OUT_VALID=0, IN_READY=1.
- ADD S=1, L=0x7FFFFFFF, R=1 → next cycle ALU_OUTPUT=0x80000000, RD_WE=1, FLAGS=1001 (N=1, V=1).
- CMP S=0, L=5, R=5 → ALU_OUTPUT=0, RD_WE=0, FLAGS=0110. Follow with SBC L=5, R=5 → 0, C=1.
- Back-to-back ADD S=1, L=0xFFFFFFFF, R=1 (C→1), then ADC L=0, R=0 → second result=1 with no bubble.
- Hold OUT_READY=0 for 3 cycles with IN_VALID=1 → IN_READY=0, first result stable, second op not accepted and flags unchanged. Release → 1 op/cycle resumes.
- WIDTH=8: SUB S=1, L=0x00, R=0x01 → 0xFF, FLAGS=1000. Then ORR S=1, SHIFT_C=1 → C=1, V unchanged. Then FLAG_LOAD=1 with a simultaneous CMP → CMP flags kept.
